// File: rtl/rename_retire_pkg.sv
// Shared sizing, commit-field helpers and reset bitmap for the rename retire block.
// The optional RN_RETIRE_CNT_EN macro adds a retired-destination counter.
package rename_retire_pkg;

  localparam int unsigned RB    = 2;
  localparam int unsigned RP    = 4;
  localparam int unsigned NREG  = 32;
  localparam int unsigned MAP_W = NREG * RB;
  localparam int unsigned BM_W  = NREG * RP;
  localparam int unsigned RD_W  = 5 + RB;
  localparam int unsigned CNT_W = 64;

  typedef logic [MAP_W-1:0] map_t;
  typedef logic [BM_W-1:0]  bitmap_t;
  typedef logic [RB-1:0]    idx_t;
  typedef logic [4:0]       areg_t;
  typedef logic [RD_W-1:0]  rd_t;

  // Retired destination is packed as {arch reg, copy idx}.
  function automatic areg_t arch_reg(input rd_t rd);
    return rd[RD_W-1:RB];
  endfunction

  function automatic idx_t copy_idx(input rd_t rd);
    return rd[RB-1:0];
  endfunction

  // Every register starts mapped to copy 0, so only that bit is in use.
  localparam bitmap_t RST_BITMAP = {NREG{RP'(1)}};

endpackage

// File: rtl/rename_retire_if.sv
// Rename/commit-side bus of the rename retire block; retire_cnt present with RN_RETIRE_CNT_EN.
interface rename_retire_if;
  import rename_retire_pkg::*;

  map_t    rnAct_X_dnxt;
  map_t    rnAct_X_qout;
  bitmap_t rnBufU_rename_set;
  bitmap_t rnBufU_qout;
  map_t    archi_X_qout;
  logic    commit_vld;
  rd_t     commit_rd0;
  logic    flush;
  bitmap_t rnBufU_free;
`ifdef RN_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
`endif

  modport master (
    output rnAct_X_dnxt, rnBufU_rename_set, commit_vld, commit_rd0, flush,
    input  rnAct_X_qout, rnBufU_qout, archi_X_qout, rnBufU_free
`ifdef RN_RETIRE_CNT_EN
    , input retire_cnt
`endif
  );

  modport slave (
    input  rnAct_X_dnxt, rnBufU_rename_set, commit_vld, commit_rd0, flush,
    output rnAct_X_qout, rnBufU_qout, archi_X_qout, rnBufU_free
`ifdef RN_RETIRE_CNT_EN
    , output retire_cnt
`endif
  );

endinterface

// File: rtl/rename_retire_expand.sv
// Expands a per-register copy mapping into the per-register one-hot usage bitmap.
module rn_onehot_expand
  import rename_retire_pkg::*;
(
  input  map_t    map_i,
  output bitmap_t bitmap_c
);

  always_comb begin
    bitmap_c = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      bitmap_c[r*RP + 32'(map_i[r*RB +: RB])] = 1'b1;
    end
  end

endmodule

// File: rtl/rename_retire.sv
// Commit-side rename state: speculative/architectural tables and physical-copy usage bitmap.
// Defining RN_RETIRE_CNT_EN adds a 64-bit count of retired destinations.
module rename_retire
  import rename_retire_pkg::*;
(
  input logic          CLK,
  input logic          RSTn,
  rename_retire_if.slave bus
);

  map_t    rn_act_q, rn_act_d;
  map_t    archi_q, archi_d;
  bitmap_t bitmap_q, bitmap_d;
  bitmap_t free_q, free_d;
  bitmap_t commit_clear_c;
  bitmap_t flush_bitmap_c;
  areg_t   cm_reg_c;
  idx_t    cm_new_c;
  idx_t    cm_old_c;

  assign cm_reg_c = arch_reg(bus.commit_rd0);
  assign cm_new_c = copy_idx(bus.commit_rd0);
  assign cm_old_c = archi_q[32'(cm_reg_c)*RB +: RB];

  // Retire: advance the architectural mapping and release the copy it replaces.
  always_comb begin
    archi_d        = archi_q;
    commit_clear_c = '0;
    if (bus.commit_vld) begin
      archi_d[32'(cm_reg_c)*RB +: RB] = cm_new_c;
      if (cm_old_c != cm_new_c) begin
        commit_clear_c[32'(cm_reg_c)*RP + 32'(cm_old_c)] = 1'b1;
      end
    end
  end

  rn_onehot_expand u_expand (
    .map_i    (archi_d),
    .bitmap_c (flush_bitmap_c)
  );

  // Flush restores speculative state from the post-commit architectural table.
  always_comb begin
    rn_act_d = bus.rnAct_X_dnxt;
    bitmap_d = (bitmap_q & ~commit_clear_c) | bus.rnBufU_rename_set;
    free_d   = commit_clear_c;
    if (bus.flush) begin
      rn_act_d = archi_d;
      bitmap_d = flush_bitmap_c;
      free_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rn_act_q <= '0;
      archi_q  <= '0;
      bitmap_q <= RST_BITMAP;
      free_q   <= '0;
    end else begin
      rn_act_q <= rn_act_d;
      archi_q  <= archi_d;
      bitmap_q <= bitmap_d;
      free_q   <= free_d;
    end
  end

  assign bus.rnAct_X_qout = rn_act_q;
  assign bus.archi_X_qout = archi_q;
  assign bus.rnBufU_qout  = bitmap_q;
  assign bus.rnBufU_free  = free_q;

`ifdef RN_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + CNT_W'(bus.commit_vld);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.retire_cnt = retire_cnt_q;
`endif

`ifndef SYNTHESIS
  // Protocol checks on the incoming commit and rename traffic.
  always @(posedge CLK) begin
    if (RSTn) begin
      if (bus.commit_vld) begin
        assert (cm_old_c != cm_new_c)
          else $error("rename_retire: commit of already-architectural copy");
      end
      if (!bus.flush) begin
        assert ((bus.rnBufU_rename_set & commit_clear_c) == '0)
          else $error("rename_retire: rename set collides with commit clear");
      end
    end
  end

  // Bitmap must always cover the architectural copy of every register.
  always @(posedge CLK) begin
    if (RSTn) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        assert ((|bitmap_q[r*RP +: RP]) && bitmap_q[r*RP + 32'(archi_q[r*RB +: RB])])
          else $error("rename_retire: bitmap invariant broken for x%0d", r);
      end
    end
  end
`endif

endmodule
